// File: rtl/bpm2per.sv
// Tempo (BPM) to beat period converter: serial restoring divide of the timepulse-tick
// count per minute by the tempo, driving a beat generator clocked by the timepulse.
module bpm2per #(
   parameter int CLK_PER_NS = 40,
   parameter int TP_CYCLE   = 5120,
   parameter int BPM_MAX    = 250,
   localparam longint unsigned DIVIDEND = 64'd60_000_000_000 / longint'(TP_CYCLE),
   localparam int PER_SIZE = $clog2(DIVIDEND + 1),
   localparam int BPM_SIZE = $clog2(BPM_MAX + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                tp_i,
   input  logic [BPM_SIZE-1:0] bpm_i,
   input  logic                bpm_valid,
   output logic [PER_SIZE-1:0] per_o,
   output logic                per_valid,
   output logic                busy_o,
   output logic                beat_o
);
   localparam int W      = PER_SIZE + BPM_SIZE;
   localparam int ITER_W = $clog2(PER_SIZE);

   if (CLK_PER_NS <= 0 || (TP_CYCLE % CLK_PER_NS) != 0) begin : g_bad_clk
      $error("TP_CYCLE must be a whole number of clock periods");
   end

   // state    | meaning
   // s_idle   | waiting for a tempo request
   // s_calc   | one quotient bit per cycle, MSB first
   // s_done   | publish quotient (or 0 for a zero tempo)
   typedef enum logic [1:0] {
      s_idle = 2'h0,
      s_calc = 2'h1,
      s_done = 2'h2
   } state_t;

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [W-1:0]        rem_q, rem_d;
   logic [W-1:0]        div_q, div_d;
   logic [W-1:0]        div_shift;
   logic [PER_SIZE-1:0] quo_q, quo_d;
   logic                zero_q, zero_d;
   logic [PER_SIZE-1:0] per_q, per_d;
   logic                pv_q, pv_d;
   logic                busy_q, busy_d;
   logic [PER_SIZE-1:0] cnt_q, cnt_d;
   logic                beat_q, beat_d;
   logic [BPM_SIZE-1:0] op_c;

   assign op_c = (bpm_i > BPM_SIZE'(BPM_MAX)) ? BPM_SIZE'(BPM_MAX) : bpm_i;

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      rem_d     = rem_q;
      div_d     = div_q;
      quo_d     = quo_q;
      zero_d    = zero_q;
      per_d     = per_q;
      pv_d      = 1'b0;
      cnt_d     = cnt_q;
      beat_d    = 1'b0;
      // Shifting before the compare makes the PER_SIZE steps produce quotient bits PER_SIZE-1..0.
      div_shift = div_q >> 1;

      case (state_q)
         s_idle: begin
            if (bpm_valid) begin
               state_d = s_calc;
               iter_d  = ITER_W'(PER_SIZE - 1);
               rem_d   = W'(DIVIDEND);
               div_d   = {op_c, {PER_SIZE{1'b0}}};
               quo_d   = '0;
               zero_d  = (bpm_i == '0);
            end
         end
         s_calc: begin
            if (div_shift <= rem_q) begin
               rem_d = rem_q - div_shift;
               quo_d = {quo_q[PER_SIZE-2:0], 1'b1};
            end else begin
               quo_d = {quo_q[PER_SIZE-2:0], 1'b0};
            end
            div_d  = div_shift;
            iter_d = iter_q - 1'b1;
            if (iter_q == '0) state_d = s_done;
         end
         s_done: begin
            state_d = s_idle;
            per_d   = zero_q ? '0 : quo_q;
            pv_d    = 1'b1;
         end
         default: state_d = s_idle;
      endcase

      busy_d = (state_d != s_idle);

      // A fresh period restarts the beat phase; a strobe in that same cycle is dropped.
      if (pv_q) begin
         cnt_d = '0;
      end else if (tp_i && per_q != '0) begin
         if (cnt_q == per_q - 1'b1) begin
            cnt_d  = '0;
            beat_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= s_idle;
         iter_q  <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         zero_q  <= 1'b0;
         per_q   <= '0;
         pv_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         beat_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         zero_q  <= zero_d;
         per_q   <= per_d;
         pv_q    <= pv_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
      end
   end

   assign per_o     = per_q;
   assign per_valid = pv_q;
   assign busy_o    = busy_q;
   assign beat_o    = beat_q;
endmodule

// File: tb/tb_bpm2per.sv
// Bench for bpm2per: a default-parameter instance for the headline numbers and a
// short-period instance for randomized beat/request traffic against a reference model.
module tb_bpm2per;
   localparam longint DIV_A = 11718750;
   localparam int     PS_A  = 24;
   localparam longint DIV_B = 1000;
   localparam int     PS_B  = 10;
   localparam int     BMAX  = 250;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_tp = 1'b0, a_valid = 1'b0;
   logic [7:0]  a_bpm = '0;
   logic [23:0] a_per;
   logic        a_pv, a_busy, a_beat;

   logic        b_tp = 1'b0, b_valid = 1'b0;
   logic [7:0]  b_bpm = '0;
   logic [9:0]  b_per;
   logic        b_pv, b_busy, b_beat;

   int errors = 0;
   int checks = 0;

   bpm2per u_dut (
      .clk_i(clk), .rst_i(rst), .tp_i(a_tp), .bpm_i(a_bpm), .bpm_valid(a_valid),
      .per_o(a_per), .per_valid(a_pv), .busy_o(a_busy), .beat_o(a_beat)
   );

   bpm2per #(.TP_CYCLE(60_000_000)) u_fast (
      .clk_i(clk), .rst_i(rst), .tp_i(b_tp), .bpm_i(b_bpm), .bpm_valid(b_valid),
      .per_o(b_per), .per_valid(b_pv), .busy_o(b_busy), .beat_o(b_beat)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   function automatic longint exp_per(input longint dividend, input int bpm);
      int b;
      b = (bpm > BMAX) ? BMAX : bpm;
      return (b == 0) ? 64'd0 : dividend / b;
   endfunction

   // Pulses a request on the default instance and returns at the per_valid cycle;
   // lat counts edges from the sampling edge (-1 on timeout).
   task automatic a_req_wait(input int bpm, output int lat, output int busy_n);
      @(negedge clk);
      a_bpm   = 8'(bpm);
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      lat     = 0;
      busy_n  = 0;
      while (a_pv !== 1'b1 && lat < 100) begin
         if (a_busy === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (a_pv !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (a_per !== 24'd0) begin errors++; $display("FAIL reset_per: got %0d want 0", a_per); end
      checks++; if ({a_pv, a_busy, a_beat} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {a_pv, a_busy, a_beat}); end
      checks++; if ({b_per, b_pv, b_busy, b_beat} !== 13'd0) begin errors++; $display("FAIL reset_fast: got %h want 0", {b_per, b_pv, b_busy, b_beat}); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({a_pv, a_busy, a_beat} !== 3'b000) begin errors++; $display("FAIL post_reset_flags: got %b want 000", {a_pv, a_busy, a_beat}); end
   endtask

   task automatic test_latency();
      int lat, busy_n;
      a_req_wait(120, lat, busy_n);
      checks++; if (lat != PS_A + 1) begin errors++; $display("FAIL latency_120: got %0d want %0d", lat, PS_A + 1); end
      checks++; if (busy_n != PS_A + 1) begin errors++; $display("FAIL busy_len_120: got %0d want %0d", busy_n, PS_A + 1); end
      checks++; if (a_per !== 24'(exp_per(DIV_A, 120))) begin errors++; $display("FAIL per_120: got %0d want %0d", a_per, exp_per(DIV_A, 120)); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_at_pv: got %b want 0", a_busy); end
      @(negedge clk);
      checks++; if (a_pv !== 1'b0) begin errors++; $display("FAIL pv_width: got %b want 0", a_pv); end
      checks++; if (a_per !== 24'd97656) begin errors++; $display("FAIL per_hold_120: got %0d want 97656", a_per); end
   endtask

   task automatic test_values();
      int vals[10];
      int lat, busy_n;
      vals = '{250, 255, 1, 120, 3, 200, 0, 0, 0, 0};
      for (int i = 6; i < 10; i++) vals[i] = $urandom_range(0, 255);
      for (int i = 0; i < 10; i++) begin
         a_req_wait(vals[i], lat, busy_n);
         checks++; if (lat != PS_A + 1) begin errors++; $display("FAIL latency_bpm%0d: got %0d want %0d", vals[i], lat, PS_A + 1); end
         checks++; if (a_per !== 24'(exp_per(DIV_A, vals[i]))) begin errors++; $display("FAIL per_bpm%0d: got %0d want %0d", vals[i], a_per, exp_per(DIV_A, vals[i])); end
      end
   endtask

   task automatic test_beat_default();
      int lat, busy_n, n, got;
      a_tp = 1'b1;
      a_req_wait(250, lat, busy_n);
      checks++; if (a_per !== 24'd46875) begin errors++; $display("FAIL per_250: got %0d want 46875", a_per); end
      n   = 0;
      got = -1;
      while (got < 0 && n < 47000) begin
         @(negedge clk);
         n++;
         if (a_beat === 1'b1) got = n;
      end
      checks++; if (got != 46876) begin errors++; $display("FAIL first_beat_250: got %0d want 46876", got); end
      @(negedge clk);
      checks++; if (a_beat !== 1'b0) begin errors++; $display("FAIL beat_width: got %b want 0", a_beat); end
      a_tp = 1'b0;
   endtask

   task automatic test_busy_ignore();
      int lat, pv_n;
      @(negedge clk);
      a_bpm   = 8'd0;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (4) @(negedge clk);
      a_bpm   = 8'd60;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      lat = 5;
      while (a_pv !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat != PS_A + 1) begin errors++; $display("FAIL latency_zero: got %0d want %0d", lat, PS_A + 1); end
      checks++; if (a_per !== 24'd0) begin errors++; $display("FAIL per_zero: got %0d want 0", a_per); end
      pv_n = 0;
      repeat (60) begin
         @(negedge clk);
         if (a_pv === 1'b1) pv_n++;
      end
      checks++; if (pv_n != 0) begin errors++; $display("FAIL busy_request_queued: got %0d pulses want 0", pv_n); end
      checks++; if (a_per !== 24'd0) begin errors++; $display("FAIL per_after_ignore: got %0d want 0", a_per); end
   endtask

   task automatic test_disable();
      int beats;
      beats = 0;
      a_tp  = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         if (a_beat === 1'b1) beats++;
      end
      a_tp = 1'b0;
      checks++; if (beats != 0) begin errors++; $display("FAIL disabled_beats: got %0d want 0", beats); end
   endtask

   task automatic test_reset_mid();
      int lat, busy_n, pv_n;
      a_req_wait(250, lat, busy_n);
      @(negedge clk);
      a_bpm   = 8'd120;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", a_busy); end
      checks++; if (a_per !== 24'd0) begin errors++; $display("FAIL reset_mid_per: got %0d want 0", a_per); end
      @(negedge clk);
      rst  = 1'b0;
      pv_n = 0;
      repeat (40) begin
         @(negedge clk);
         if (a_pv === 1'b1) pv_n++;
      end
      checks++; if (pv_n != 0) begin errors++; $display("FAIL reset_mid_pv: got %0d pulses want 0", pv_n); end
      a_req_wait(120, lat, busy_n);
      checks++; if (lat != PS_A + 1) begin errors++; $display("FAIL latency_after_reset: got %0d want %0d", lat, PS_A + 1); end
      checks++; if (a_per !== 24'd97656) begin errors++; $display("FAIL per_after_reset: got %0d want 97656", a_per); end
   endtask

   // Randomized requests and strobes on the short-period instance. The model tracks
   // request phase by edges since acceptance and beats as every per-th strobe since load.
   task automatic test_fast_random();
      int  ph, fper, pend, n, sel;
      bit  exp_busy, exp_pv, exp_beat;
      ph = 0; fper = 0; pend = 0; n = 0; exp_beat = 1'b0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(negedge clk);
         exp_busy = (ph >= 1 && ph <= PS_B + 1);
         exp_pv   = (ph == PS_B + 2);
         if (exp_pv) fper = pend;
         checks++; if (b_busy !== exp_busy) begin errors++; $display("FAIL fast_busy c%0d: got %b want %b", cyc, b_busy, exp_busy); end
         checks++; if (b_pv !== exp_pv) begin errors++; $display("FAIL fast_pv c%0d: got %b want %b", cyc, b_pv, exp_pv); end
         checks++; if (b_per !== 10'(fper)) begin errors++; $display("FAIL fast_per c%0d: got %0d want %0d", cyc, b_per, fper); end
         checks++; if (b_beat !== exp_beat) begin errors++; $display("FAIL fast_beat c%0d: got %b want %b", cyc, b_beat, exp_beat); end

         b_tp    = ($urandom_range(0, 2) != 0);
         b_valid = ($urandom_range(0, 24) == 0);
         sel     = $urandom_range(0, 3);
         case (sel)
            0:       b_bpm = 8'd0;
            1:       b_bpm = 8'($urandom_range(240, 255));
            2:       b_bpm = 8'($urandom_range(100, 239));
            default: b_bpm = 8'($urandom_range(1, 99));
         endcase

         exp_beat = 1'b0;
         if (exp_pv) begin
            n = 0;
         end else if (b_tp && fper != 0) begin
            n++;
            if (n % fper == 0) exp_beat = 1'b1;
         end
         if (b_valid && !exp_busy) begin
            ph   = 1;
            pend = int'(exp_per(DIV_B, int'(b_bpm)));
         end else if (ph != 0 && ph < PS_B + 2) begin
            ph++;
         end else begin
            ph = 0;
         end
      end
      @(negedge clk);
      b_valid = 1'b0;
      b_tp    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_values();
      test_beat_default();
      test_busy_ignore();
      test_disable();
      test_reset_mid();
      test_fast_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
